// File: rtl/level_tile_fetcher.sv
`default_nettype none
// ============================================================================
// level_tile_fetcher : level tile RAM with ROM loader, display and query ports
// Revision 1.0
// ============================================================================
module level_tile_fetcher #(
  parameter int H_OFFSET   = 144,
  parameter int V_OFFSET   = 35,
  parameter int H_TOTAL    = 800,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int WALL_ID    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameStart,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        levelReq,
  input  logic [1:0]  levelSel,
  output logic [10:0] romAddr,
  input  logic [2:0]  romData,
  input  logic [4:0]  qCol,
  input  logic [3:0]  qRow,
  output logic [2:0]  qType,
  output logic [2:0]  blockType,
  output logic        loading,
  output logic        levelReady
);

  localparam int         TILES    = MAP_COLS * MAP_ROWS;
  localparam logic [8:0] LAST_IDX = 9'(TILES - 1);
  localparam logic [10:0] H_LO    = 11'(H_OFFSET);
  localparam logic [10:0] H_HI    = 11'(H_OFFSET + 640);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [9:0]  V_LO    = 10'(V_OFFSET);
  localparam logic [9:0]  V_HI    = 10'(V_OFFSET + 480);
  localparam logic [2:0]  WALL    = 3'(WALL_ID);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [2:0] mem [TILES];

  logic [1:0]  state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [1:0]  pend_level_q, pend_level_d;
  logic        pend_req_q, pend_req_d;
  logic [1:0]  load_level_q, load_level_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic        level_ready_q, level_ready_d;
  logic        disp_act_q, disp_act_d;
  logic [8:0]  disp_addr_q, disp_addr_d;
  logic [2:0]  block_type_q, block_type_d;
  logic [2:0]  q_type_q, q_type_d;

  logic [10:0] xl, xoff;
  logic [9:0]  yoff;
  logic        x_act, y_act;
  logic [8:0]  q_idx;

  function automatic logic [8:0] tile_index(input logic [3:0] row, input logic [4:0] col);
    return ({5'd0, row} << 4) + ({5'd0, row} << 2) + {4'd0, col};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      idx_q         <= 9'd0;
      pend_level_q  <= 2'd0;
      pend_req_q    <= 1'b0;
      load_level_q  <= 2'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 9'd0;
      level_ready_q <= 1'b0;
      disp_act_q    <= 1'b0;
      disp_addr_q   <= 9'd0;
      block_type_q  <= 3'd0;
      q_type_q      <= WALL;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pend_level_q  <= pend_level_d;
      pend_req_q    <= pend_req_d;
      load_level_q  <= load_level_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      level_ready_q <= level_ready_d;
      disp_act_q    <= disp_act_d;
      disp_addr_q   <= disp_addr_d;
      block_type_q  <= block_type_d;
      q_type_q      <= q_type_d;
    end
  end

  // ROM data lags its address by one cycle, so the write uses the previous index.
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= romData;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_level_d = pend_level_q;
    pend_req_d   = pend_req_q;
    load_level_d = load_level_q;
    case (state_q)
      ST_IDLE: begin
        if (levelReq) begin
          pend_level_d = levelSel;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (levelReq) pend_level_d = levelSel;
        if (frameStart) begin
          state_d      = ST_LOAD;
          idx_d        = 9'd0;
          load_level_d = levelReq ? levelSel : pend_level_q;
        end
      end
      ST_LOAD: begin
        if (levelReq) begin
          pend_req_d   = 1'b1;
          pend_level_d = levelSel;
        end
        if (idx_q == LAST_IDX) state_d = ST_FLUSH;
        else                   idx_d   = idx_q + 9'd1;
      end
      default: begin
        if (levelReq) pend_level_d = levelSel;
        pend_req_d = 1'b0;
        state_d    = (pend_req_q || levelReq) ? ST_WAIT : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    loading       = (state_q != ST_IDLE);
    romAddr       = (state_q == ST_LOAD) ? {load_level_q, idx_q} : 11'd0;
    wr_en_d       = (state_q == ST_LOAD);
    wr_addr_d     = idx_q;
    level_ready_d = (state_q == ST_FLUSH);

    // Stage 1 looks two pixels ahead so the registered RAM output lines up with hCount.
    xl          = {1'b0, hCount} + 11'd2;
    xoff        = xl - H_LO;
    yoff        = vCount - V_LO;
    x_act       = (xl < H_TOT) && (xl >= H_LO) && (xl < H_HI);
    y_act       = (vCount >= V_LO) && (vCount < V_HI);
    disp_act_d  = x_act && y_act && !loading;
    disp_addr_d = (x_act && y_act) ? tile_index(4'(yoff >> TILE_SHIFT), 5'(xoff >> TILE_SHIFT))
                                   : 9'd0;
    block_type_d = (disp_act_q && !loading) ? mem[disp_addr_q] : 3'd0;

    q_idx    = tile_index(qRow, qCol);
    q_type_d = (qCol >= 5'(MAP_COLS) || qRow >= 4'(MAP_ROWS) || loading) ? WALL : mem[q_idx];

    blockType  = block_type_q;
    qType      = q_type_q;
    levelReady = level_ready_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_level_tile_fetcher.sv
`default_nettype none
// Directed bench for level_tile_fetcher with a behavioural synchronous level ROM.
module tb_level_tile_fetcher;

  logic        clk = 1'b0;
  logic        reset, frameStart, levelReq;
  logic [9:0]  hCount, vCount;
  logic [1:0]  levelSel;
  logic [10:0] romAddr;
  logic [2:0]  romData;
  logic [4:0]  qCol;
  logic [3:0]  qRow;
  logic [2:0]  qType, blockType;
  logic        loading, levelReady;

  int n_checks = 0;
  int n_fail   = 0;
  int blk_bad  = 0;
  logic mon_en = 1'b0;

  level_tile_fetcher dut (
    .clk(clk), .reset(reset), .frameStart(frameStart),
    .hCount(hCount), .vCount(vCount),
    .levelReq(levelReq), .levelSel(levelSel),
    .romAddr(romAddr), .romData(romData),
    .qCol(qCol), .qRow(qRow), .qType(qType),
    .blockType(blockType), .loading(loading), .levelReady(levelReady)
  );

  always #5 clk = ~clk;

  function automatic int rom_val(input int lvl, input int i);
    case (lvl)
      0:       return i % 4;
      1:       return (i + 1) % 8;
      2:       return (3 * i + 2) % 8;
      default: return (5 * i + 3) % 8;
    endcase
  endfunction

  always @(posedge clk) romData <= 3'(rom_val(int'(romAddr[10:9]), int'(romAddr[8:0])));

  always @(negedge clk) if (mon_en && blockType != 3'd0) blk_bad <= blk_bad + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!levelReady && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_req(input logic [1:0] sel, input logic fs);
    levelReq = 1'b1; levelSel = sel; frameStart = fs;
    tick();
    levelReq = 1'b0; frameStart = 1'b0;
  endtask

  task automatic pulse_frame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic verify_ram(input int lvl, input string name);
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      qRow = 4'(i / 20); qCol = 5'(i % 20);
      tick();
      if (int'(qType) != rom_val(lvl, i)) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic query(input int c, input int r, input int exp, input string name);
    qCol = 5'(c); qRow = 4'(r);
    tick();
    check(name, int'(qType), exp);
  endtask

  typedef struct {
    int h;
    int v;
    int exp;
  } disp_vec_t;

  disp_vec_t dv[15];

  initial begin
    int n;
    // Level 1 loaded: tile i holds (i+1)%8
    dv[0]  = '{143, 35, 0};
    dv[1]  = '{144, 35, 1};
    dv[2]  = '{160, 35, 1};
    dv[3]  = '{175, 35, 1};
    dv[4]  = '{176, 35, 2};
    dv[5]  = '{783, 35, 4};
    dv[6]  = '{784, 35, 0};
    dv[7]  = '{796, 35, 0};
    dv[8]  = '{799, 35, 0};
    dv[9]  = '{0,   35, 0};
    dv[10] = '{1,   35, 0};
    dv[11] = '{150, 34, 0};
    dv[12] = '{144, 67, 5};
    dv[13] = '{783, 514, 4};
    dv[14] = '{783, 515, 0};

    reset = 1'b1; frameStart = 1'b0; levelReq = 1'b0; levelSel = 2'd0;
    hCount = 10'd0; vCount = 10'd0; qCol = 5'd0; qRow = 4'd0;

    // Reset and initial load of level 0
    tick(); tick();
    check("rst_blockType", int'(blockType), 0);
    check("rst_qType", int'(qType), 1);
    check("rst_levelReady", int'(levelReady), 0);
    check("rst_loading", int'(loading), 1);
    check("rst_romAddr", int'(romAddr), 0);
    reset = 1'b0;
    wait_ready(n);
    check("reset_load_cycles", n, 301);
    tick();
    check("levelReady_one_cycle", int'(levelReady), 0);
    check("loading_idle", int'(loading), 0);
    query(3, 2, 3, "query_3_2");
    query(20, 0, 1, "query_col_oob");
    query(0, 15, 1, "query_row_oob");
    query(19, 14, 3, "query_last");

    // Load level 1 for the display tests
    pulse_req(2'd1, 1'b0);
    check("loading_after_req", int'(loading), 1);
    tick(); tick();
    pulse_frame();
    wait_ready(n);
    check("lvl1_load_cycles", n, 301);
    tick();

    for (int k = 0; k < 15; k++) begin
      vCount = 10'(dv[k].v);
      hCount = 10'((dv[k].h + 798) % 800);
      tick();
      hCount = 10'((dv[k].h + 799) % 800);
      tick();
      hCount = 10'(dv[k].h);
      check($sformatf("disp_h%0d_v%0d", dv[k].h, dv[k].v), int'(blockType), dv[k].exp);
    end

    // Continuous sweep across the line end and wrap
    vCount = 10'd35;
    for (int h = 780; h < 804; h++) begin
      hCount = 10'(h % 800);
      tick();
      if (h >= 798) check($sformatf("sweep_h%0d", h % 800), int'(blockType), 0);
    end

    // Request coincident with frameStart waits for the next frame
    vCount = 10'd35; hCount = 10'd150;
    tick(); tick();
    check("disp_before_req", int'(blockType), 1);
    pulse_req(2'd2, 1'b1);
    check("fs_req_loading", int'(loading), 1);
    check("fs_req_no_load", int'(romAddr), 0);
    tick();
    blk_bad = 0; mon_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("wait_romAddr", int'(romAddr), 0);
    pulse_frame();
    check("lvl2_first_addr", int'(romAddr), 'h400);
    wait_ready(n);
    check("lvl2_load_cycles", n, 301);
    mon_en = 1'b0;
    check("blockType_zero_while_loading", blk_bad, 0);
    tick(); tick();
    check("disp_after_lvl2", int'(blockType), 2);
    verify_ram(2, "ram_lvl2");

    // Request arriving mid-load is queued until the following frame
    pulse_req(2'd1, 1'b0);
    tick();
    pulse_frame();
    for (int i = 0; i < 100; i++) tick();
    check("lvl1_idx100", int'(romAddr), 'h264);
    pulse_req(2'd3, 1'b0);
    wait_ready(n);
    check("mid_req_cycles", n, 200);
    check("mid_req_still_loading", int'(loading), 1);
    tick(); tick();
    check("mid_req_wait_addr", int'(romAddr), 0);
    check("mid_req_wait_loading", int'(loading), 1);
    pulse_frame();
    check("lvl3_first_addr", int'(romAddr), 'h600);
    wait_ready(n);
    check("lvl3_load_cycles", n, 301);
    verify_ram(3, "ram_lvl3");

    // Last request wins in WAIT_FRAME; reset aborts a load and reloads level 0
    pulse_req(2'd1, 1'b0);
    tick();
    pulse_req(2'd2, 1'b0);
    tick();
    pulse_frame();
    check("last_req_wins", int'(romAddr), 'h400);
    for (int i = 0; i < 150; i++) tick();
    check("lvl2_idx150", int'(romAddr), 'h496);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midload_rst_addr", int'(romAddr), 0);
    check("midload_rst_loading", int'(loading), 1);
    query(0, 3, 1, "query_during_load");
    wait_ready(n);
    check("reload_cycles", n, 300);
    verify_ram(0, "ram_lvl0_reload");
    query(20, 0, 1, "query_oob_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/level_tile_fetcher.md
Name: level_tile_fetcher

Overview:
Holds the current level's tile map in on-chip RAM and produces the per-pixel `blockType` consumed by the display controller, pixel-aligned with `hCount`/`vCount`. Loads a level from the level ROM on reset, and on request at a frame boundary. Also serves a 1-cycle tile query port for the physics/collision logic.

Parameters:
- H_OFFSET, 144: hCount of the first active pixel.
- V_OFFSET, 35: vCount of the first active line.
- H_TOTAL, 800: hCount period; hCount runs 0..H_TOTAL-1.
- TILE_SHIFT, 5: log2 of the tile size in pixels (32x32 tiles).
- MAP_COLS, 20: tiles per row.
- MAP_ROWS, 15: tile rows.
- WALL_ID, 1: type returned for out-of-range queries and for queries during a load.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- frameStart, input, 1: one-cycle pulse at the start of each frame.
- hCount, input, 10: current pixel column.
- vCount, input, 10: current pixel line.
- levelReq, input, 1: one-cycle pulse requesting a level load.
- levelSel, input, 2: level number; sampled only when levelReq=1.
- romAddr, output, 11: level ROM address, {level[1:0], tileIdx[8:0]}.
- romData, input, 3: ROM tile type; synchronous ROM, valid 1 cycle after romAddr.
- qCol, input, 5: query tile column.
- qRow, input, 4: query tile row.
- qType, output, 3: tile type at (qCol,qRow), valid 1 cycle after the query.
- blockType, output, 3: tile type under (hCount,vCount), same cycle.
- loading, output, 1: high while a load is pending or in progress.
- levelReady, output, 1: one-cycle pulse when a load completes.

Behaviour:
- **Tile RAM:** MAP_COLS*MAP_ROWS = 300 entries x 3 bits; one write port and two synchronous read ports (display, query).
- **Tile index:** row*20 + col, computed as (row<<4)+(row<<2)+col. Width is 9 bits; the maximum index is 299.

Display path:
- The path is a 2-stage pipeline evaluated for lookahead pixel xl = hCount+2 on the current vCount.
  - Stage 1 forms the RAM address and an active flag.
  - Stage 2 registers the RAM output into blockType.
- Result: blockType presented while hCount=h is the tile at (h,vCount).
- Active region: H_OFFSET <= x < H_OFFSET+640 and V_OFFSET <= y < V_OFFSET+480.
  - col = (x-H_OFFSET)>>TILE_SHIFT; row = (y-V_OFFSET)>>TILE_SHIFT.
- Lookahead wrap: when xl >= H_TOTAL the pixel is treated as inactive; it is not wrapped to the next line.
- The pipeline outputs 0 for inactive pixels, and also while loading=1.

Query path:
- qType is registered, with 1-cycle latency.
- qType = WALL_ID if qCol >= MAP_COLS, qRow >= MAP_ROWS, or loading=1 at query time.
- Otherwise qType = RAM[qRow*20+qCol].

Load FSM states: IDLE, WAIT_FRAME, LOAD, FLUSH.
- **IDLE:**
  - On levelReq: pendLevel <= levelSel, go to WAIT_FRAME.
  - A frameStart in the same cycle as levelReq is not used; the load waits for the next frameStart.
- **WAIT_FRAME:**
  - On frameStart: go to LOAD with idx=0.
  - A levelReq here overwrites pendLevel (last request wins).
- **LOAD:**
  - Each cycle: romAddr = {pendLevel, idx} and idx increments.
  - The RAM write of romData uses the address delayed one cycle (idx-1).
  - At idx=299 go to FLUSH.
- **FLUSH:**
  - Writes the final word (index 299).
  - Pulses levelReady for 1 cycle and returns to IDLE.
  - If a levelReq arrived during LOAD or FLUSH, it was latched in pendReq/pendLevel and the FSM goes to WAIT_FRAME instead.
- **Load duration:** 301 cycles from entering LOAD to levelReady.
- **loading:** equals 1 in WAIT_FRAME, LOAD and FLUSH.
- **romAddr:** 0 outside LOAD.

Reset:
- Aborts any load; clears pendReq; pendLevel <= 0.
- Enters LOAD directly, so level 0 loads without waiting for frameStart.
- Reset values: blockType=0, qType=WALL_ID, levelReady=0, loading=1, romAddr=0, pipeline active flags=0.

Test Plan:
1. **Reset load:** assert reset 1 cycle; ROM level 0 holds type=(idx%4).
   - levelReady pulses exactly 301 cycles after reset deasserts.
   - Query (3,2) returns 3, since idx 43 %4 = 3.
2. **Pixel alignment:** RAM[0]=1, RAM[1]=2; vCount=35.
   - blockType=1 for hCount 144..175, =2 at 176, =0 at 143 and at 784.
3. **Line edges:** hCount sweeps 796..799, then wraps to 0.
   - blockType=0 throughout; no spurious tile at hCount 0..1.
4. **Frame-gated request:** levelReq with levelSel=2 pulsed in the same cycle as a frameStart.
   - loading=1 immediately.
   - LOAD starts only at the following frameStart; romAddr first = 0x400.
   - blockType=0 until levelReady.
5. **Request during load:** levelReq with levelSel=3 at LOAD idx=100.
   - Current load completes (levelReady pulse); FSM enters WAIT_FRAME.
   - Level 3 loads on the next frameStart; final RAM matches level 3.
6. **Out-of-range query / reset mid-load:**
   - Query (20,0) -> qType=1.
   - Reset at LOAD idx=150 of level 2 -> level 0 is reloaded; RAM fully equals level 0 after levelReady.
